// File: rtl/bitblade_psum_accum_pkg.sv
// Shared constants and brick-geometry helpers for the BitBlade partial-sum accumulator.
// Precision fields are 2-bit codes; code 2'b11 is treated like 2b.
package bitblade_psum_accum_pkg;

  localparam int BP_W_DEF  = 5;
  localparam int ACC_W_DEF = 32;
  localparam int N_BRICK   = 16;

  localparam logic [1:0] PREC_2B = 2'b00;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_8B = 2'b10;

  function automatic logic [1:0] prec_log2(input logic [1:0] code);
    case (code)
      PREC_4B: return 2'd1;
      PREC_8B: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_of(input logic [3:0] b, input logic [1:0] li,
                                         input logic [1:0] lw);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = {2'b00, b[3:2] >> li};
    lo = {2'b00, b[1:0] >> lw};
    return (hi << (2'd2 - lw)) | lo;
  endfunction

  // Shift of brick b inside its fused group: 2*(ki+kw), at most 12.
  function automatic logic [3:0] brick_shift(input logic [3:0] b, input logic [1:0] li,
                                             input logic [1:0] lw);
    logic [2:0] mi;
    logic [2:0] mw;
    logic [2:0] s;
    mi = 3'((3'd1 << li) - 3'd1);
    mw = 3'((3'd1 << lw) - 3'd1);
    s  = {1'b0, b[3:2] & mi[1:0]} + {1'b0, b[1:0] & mw[1:0]};
    return {s, 1'b0};
  endfunction

endpackage

// File: rtl/bitblade_psum_accum_shift_reduce.sv
// Combinational brick shift and reduction of the 16 brick products into N_OUT lane sums.
// Lanes that receive no brick under the current geometry stay zero.
module bitblade_shift_reduce
  import bitblade_psum_accum_pkg::*;
#(
  parameter int BP_W  = BP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [1:0]                li_i,
  input  logic [1:0]                lw_i,
  input  logic [16*BP_W-1:0]        bp_i,
  output logic [15:0][ACC_W-1:0]    lane_sum_o
);

  logic [3:0]       lane_s;
  logic [ACC_W-1:0] term_s;

  always_comb begin
    lane_sum_o = '0;
    lane_s     = 4'd0;
    term_s     = '0;
    for (int b = 0; b < N_BRICK; b++) begin
      lane_s = lane_of(4'(b), li_i, lw_i);
      term_s = ACC_W'($signed(bp_i[b*BP_W +: BP_W])) << brick_shift(4'(b), li_i, lw_i);
      lane_sum_o[lane_s] = lane_sum_o[lane_s] + term_s;
    end
  end

endmodule

// File: rtl/bitblade_psum_accum.sv
// Accumulates fused brick partial sums across beats and presents one result per
// dot-product through a valid/ready output register.
module bitblade_psum_accum
  import bitblade_psum_accum_pkg::*;
#(
  parameter int BP_W  = BP_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            Precision,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [16*BP_W-1:0]    BP,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*ACC_W-1:0]   ACC_OUT,
  output logic [4:0]            n_out,
  output logic [15:0]           ovf,
  output logic                  busy
);

  logic [3:0]             prec_q, prec_d;
  logic                   busy_q, busy_d;
  logic [15:0][ACC_W-1:0] acc_q, acc_d;
  logic [15:0]            ovf_acc_q, ovf_acc_d;
  logic [15:0][ACC_W-1:0] acc_out_q, acc_out_d;
  logic [4:0]             n_out_q, n_out_d;
  logic [15:0]            ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;

  logic [3:0]             eff_prec_s;
  logic [1:0]             li_s, lw_s;
  logic [15:0][ACC_W-1:0] lane_sum_s, sum_s;
  logic [15:0]            add_ovf_s;
  logic                   accept_s;

  // The first beat of a job uses the live code; later beats use the latched one.
  assign eff_prec_s = busy_q ? prec_q : Precision;
  assign li_s       = prec_log2(eff_prec_s[3:2]);
  assign lw_s       = prec_log2(eff_prec_s[1:0]);
  assign in_ready   = !out_valid_q || out_ready;
  assign accept_s   = in_valid && in_ready;

  bitblade_shift_reduce #(.BP_W(BP_W), .ACC_W(ACC_W)) u_shift_reduce (
    .li_i       (li_s),
    .lw_i       (lw_s),
    .bp_i       (BP),
    .lane_sum_o (lane_sum_s)
  );

  always_comb begin
    sum_s     = '0;
    add_ovf_s = '0;
    for (int o = 0; o < N_BRICK; o++) begin
      sum_s[o]     = acc_q[o] + lane_sum_s[o];
      add_ovf_s[o] = (acc_q[o][ACC_W-1] == lane_sum_s[o][ACC_W-1]) &&
                     (sum_s[o][ACC_W-1] != acc_q[o][ACC_W-1]);
    end
  end

  always_comb begin
    prec_d      = prec_q;
    busy_d      = busy_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    acc_out_d   = acc_out_q;
    n_out_d     = n_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (accept_s) begin
      if (!busy_q) begin
        prec_d = Precision;
      end else begin
        prec_d = prec_q;
      end
      if (in_last) begin
        acc_out_d   = sum_s;
        ovf_d       = ovf_acc_q | add_ovf_s;
        n_out_d     = 5'd16 >> ({1'b0, li_s} + {1'b0, lw_s});
        out_valid_d = 1'b1;
        acc_d       = '0;
        ovf_acc_d   = '0;
        busy_d      = 1'b0;
      end else begin
        acc_d     = sum_s;
        ovf_acc_d = ovf_acc_q | add_ovf_s;
        busy_d    = 1'b1;
      end
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prec_q      <= 4'b0000;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      ovf_acc_q   <= '0;
      acc_out_q   <= '0;
      n_out_q     <= 5'd0;
      ovf_q       <= 16'd0;
      out_valid_q <= 1'b0;
    end else begin
      prec_q      <= prec_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      acc_out_q   <= acc_out_d;
      n_out_q     <= n_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign ACC_OUT   = acc_out_q;
  assign n_out     = n_out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bitblade_psum_accum.sv
// Self-checking bench: directed table, hand-written handshake/reset/overflow sequences,
// and randomized jobs checked against an arithmetic model of the fused-brick reduction.
module tb_bitblade_psum_accum;

  localparam int BW  = 5;
  localparam int AW  = 32;
  localparam int AW8 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [3:0]        prec;
  logic              v32, v8, last, ordy;
  logic [16*BW-1:0]  bp;
  logic              rdy32, oval32, busy32;
  logic [16*AW-1:0]  acc32;
  logic [4:0]        n32;
  logic [15:0]       ovf32;
  logic              rdy8, oval8, busy8;
  logic [16*AW8-1:0] acc8;
  logic [4:0]        n8;
  logic [15:0]       ovf8;

  bitblade_psum_accum #(.BP_W(BW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .Precision(prec), .in_valid(v32), .in_ready(rdy32),
    .in_last(last), .BP(bp), .out_valid(oval32), .out_ready(ordy), .ACC_OUT(acc32),
    .n_out(n32), .ovf(ovf32), .busy(busy32)
  );

  bitblade_psum_accum #(.BP_W(BW), .ACC_W(AW8)) dut8 (
    .clk(clk), .rst_n(rst_n), .Precision(prec), .in_valid(v8), .in_ready(rdy8),
    .in_last(last), .BP(bp), .out_valid(oval8), .out_ready(ordy), .ACC_OUT(acc8),
    .n_out(n8), .ovf(ovf8), .busy(busy8)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Number of 2b bricks per operand for a precision field.
  function automatic int nbr(input logic [1:0] c);
    if (c == 2'b01) return 2;
    if (c == 2'b10) return 4;
    return 1;
  endfunction

  // Reference reduction: each brick scaled by 4^(position in operand), summed per output.
  function automatic void model_lanes(input logic [3:0] p, input int bpa[16], output longint ls[16]);
    int ni, nw, ib, wb, lane;
    ni = nbr(p[3:2]);
    nw = nbr(p[1:0]);
    for (int o = 0; o < 16; o++) ls[o] = 0;
    for (int b = 0; b < 16; b++) begin
      ib = b / 4;
      wb = b % 4;
      lane = (ib / ni) * (4 / nw) + wb / nw;
      ls[lane] += longint'(bpa[b]) * (longint'(1) << (2 * ((ib % ni) + (wb % nw))));
    end
  endfunction

  function automatic logic [511:0] pack32(input longint ls[16]);
    logic [511:0] r;
    logic [63:0]  t;
    r = '0;
    for (int o = 0; o < 16; o++) begin
      t = ls[o];
      r[o*32 +: 32] = t[31:0];
    end
    return r;
  endfunction

  task automatic send(input int sel, input logic [3:0] p, input int bpa[16], input bit l);
    int n;
    prec = p;
    for (int b = 0; b < 16; b++) bp[b*BW +: BW] = BW'(bpa[b]);
    last = l;
    if (sel == 0) v32 = 1'b1;
    else v8 = 1'b1;
    n = 0;
    #1;
    while (!((sel == 0) ? rdy32 : rdy8) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 512'd0, 512'd1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    v8 = 1'b0;
    last = 1'b0;
  endtask

  task automatic fill(output int bpa[16], input int val, input int only_b);
    for (int b = 0; b < 16; b++) bpa[b] = (only_b < 0 || only_b == b) ? val : 0;
  endtask

  typedef struct {
    logic [3:0] prec;
    int beats;
    int bpv;
    int only_b;
    int exp_n;
    int exp_k;
    int exp_val;
  } vec_t;

  vec_t tbl[5];
  int bpa[16];
  longint ls[16], accm[16];
  logic [511:0] e, held;
  logic [15:0] movf;
  logic [31:0] tv;

  initial begin
    rst_n = 1'b0; prec = 4'b0000; v32 = 1'b0; v8 = 1'b0; last = 1'b0; ordy = 1'b1; bp = '0;
    tbl[0] = '{4'b0000, 3, 1, -1, 16, 16, 3};
    tbl[1] = '{4'b1010, 1, 1, -1, 1, 1, 7225};
    tbl[2] = '{4'b0100, 1, 1, 4, 8, 1, 4};
    tbl[3] = '{4'b0010, 2, 1, -1, 4, 4, 170};
    tbl[4] = '{4'b1000, 1, -1, -1, 4, 4, -85};
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 512'(oval32), 512'd0);
    chk("rst_acc_out", 512'(acc32), 512'd0);
    chk("rst_n_out", 512'(n32), 512'd0);
    chk("rst_ovf", 512'(ovf32), 512'd0);
    chk("rst_busy", 512'(busy32), 512'd0);
    chk("rst_in_ready", 512'(rdy32), 512'd1);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      fill(bpa, tbl[i].bpv, tbl[i].only_b);
      for (int k = 0; k < tbl[i].beats; k++) begin
        send(0, tbl[i].prec, bpa, k == tbl[i].beats - 1);
        if (k == 0 && tbl[i].beats > 1) chk("tbl_busy", 512'(busy32), 512'd1);
      end
      e = '0;
      tv = tbl[i].exp_val;
      for (int o = 0; o < tbl[i].exp_k; o++) e[o*32 +: 32] = tv;
      chk($sformatf("tbl%0d_valid", i), 512'(oval32), 512'd1);
      chk($sformatf("tbl%0d_n_out", i), 512'(n32), 512'(tbl[i].exp_n));
      chk($sformatf("tbl%0d_acc", i), 512'(acc32), e);
      chk($sformatf("tbl%0d_ovf", i), 512'(ovf32), 512'd0);
      chk($sformatf("tbl%0d_busy", i), 512'(busy32), 512'd0);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid_drop", i), 512'(oval32), 512'd0);
    end

    // Backpressure: pending result blocks the next job until drained.
    ordy = 1'b0;
    fill(bpa, 1, -1);
    send(0, 4'b0000, bpa, 1'b1);
    held = 512'(acc32);
    fill(bpa, 2, -1);
    prec = 4'b0000;
    for (int b = 0; b < 16; b++) bp[b*BW +: BW] = BW'(bpa[b]);
    v32 = 1'b1;
    #1;
    chk("bp_in_ready_low", 512'(rdy32), 512'd0);
    @(posedge clk);
    #1;
    chk("bp_held_valid", 512'(oval32), 512'd1);
    chk("bp_held_acc", 512'(acc32), held);
    chk("bp_busy_idle", 512'(busy32), 512'd0);
    ordy = 1'b1;
    #1;
    chk("bp_in_ready_high", 512'(rdy32), 512'd1);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    chk("bp_drained", 512'(oval32), 512'd0);
    chk("bp_busy_after", 512'(busy32), 512'd1);
    send(0, 4'b0000, bpa, 1'b1);
    e = '0;
    for (int o = 0; o < 16; o++) e[o*32 +: 32] = 32'd4;
    chk("bp_second_acc", 512'(acc32), e);
    chk("bp_second_n", 512'(n32), 512'd16);

    // Precision change mid-job is ignored.
    fill(bpa, 1, -1);
    send(0, 4'b0000, bpa, 1'b0);
    send(0, 4'b1010, bpa, 1'b1);
    e = '0;
    for (int o = 0; o < 16; o++) e[o*32 +: 32] = 32'd2;
    chk("latch_acc", 512'(acc32), e);
    chk("latch_n", 512'(n32), 512'd16);

    // Narrow accumulator wraps and flags overflow on every lane.
    fill(bpa, 15, -1);
    for (int k = 0; k < 9; k++) send(1, 4'b0000, bpa, k == 8);
    e = '0;
    for (int o = 0; o < 16; o++) e[o*8 +: 8] = 8'h87;
    chk("w8_acc", 512'(acc8), e);
    chk("w8_ovf", 512'(ovf8), 512'hFFFF);
    chk("w8_n", 512'(n8), 512'd16);
    @(posedge clk);
    #1;

    // Reset with a pending result, then with an open job.
    ordy = 1'b0;
    fill(bpa, 1, -1);
    send(0, 4'b0000, bpa, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 512'(oval32), 512'd0);
    chk("arst_acc", 512'(acc32), 512'd0);
    chk("arst_n", 512'(n32), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b1;
    fill(bpa, 5, -1);
    send(0, 4'b0000, bpa, 1'b0);
    chk("arst_busy_before", 512'(busy32), 512'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 512'(busy32), 512'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(bpa, 1, -1);
    send(0, 4'b0000, bpa, 1'b1);
    e = '0;
    for (int o = 0; o < 16; o++) e[o*32 +: 32] = 32'd1;
    chk("arst_discard", 512'(acc32), e);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 40; j++) begin
      logic [3:0] jp;
      int nb;
      jp = 4'($urandom_range(15));
      nb = $urandom_range(4, 1);
      for (int o = 0; o < 16; o++) accm[o] = 0;
      movf = '0;
      for (int k = 0; k < nb; k++) begin
        for (int b = 0; b < 16; b++) bpa[b] = int'($urandom_range(31)) - 16;
        model_lanes(jp, bpa, ls);
        for (int o = 0; o < 16; o++) begin
          accm[o] += ls[o];
          if (accm[o] > 64'sd2147483647 || accm[o] < -64'sd2147483648) movf[o] = 1'b1;
          accm[o] = longint'($signed(32'(accm[o])));
        end
        if ($urandom_range(3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(0, (k == 0) ? jp : 4'($urandom_range(15)), bpa, k == nb - 1);
      end
      chk($sformatf("rnd%0d_acc", j), 512'(acc32), pack32(accm));
      chk($sformatf("rnd%0d_n", j), 512'(n32), 512'(16 / (nbr(jp[3:2]) * nbr(jp[1:0]))));
      chk($sformatf("rnd%0d_ovf", j), 512'(ovf32), 512'(movf));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
